unpack_stream: RTL and testbench

Word-to-byte unpacker for the NPU datapath. Accepts 32-bit packed words over a valid/ready handshake and emits their four bytes one per cycle, least-significant byte first, each widened to the 24-bit PE operand width. It sits between on-chip word storage and the PE input lanes. It is the read-side counterpart of the byte packer that assembles PE results into words.

---
 rtl/npu_pkg.sv | 24 ++
 rtl/unpack_stream.sv | 121 ++++++++++++
 tb/tb_unpack_stream.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/npu_pkg.sv
// Shared NPU datapath constants, state encoding and element-extension helper.
package npu_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam int OUT_W  = 24;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } unpack_state_t;

  // Widen one byte to the PE operand width, signed or unsigned.
  function automatic logic [OUT_W-1:0] ext_byte(input logic [BYTE_W-1:0] b,
                                                input logic              sign_ext);
    logic signed [BYTE_W-1:0] sb;
    logic        [OUT_W-1:0]  r;
    sb = b;
    if (sign_ext) r = OUT_W'(sb);
    else          r = OUT_W'(b);
    return r;
  endfunction

endpackage

// File: rtl/unpack_stream.sv
// Word-to-byte unpacker: holds one packed word and emits its bytes LSB first,
// one per cycle, widened to the PE operand width.
module unpack_stream #(
  parameter int LANES  = 4,
  parameter int BYTE_W = 8,
  parameter int OUT_W  = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    sign_ext,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*BYTE_W-1:0] in_data,
  input  logic                    in_last,
  input  logic [1:0]              in_count,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_data,
  output logic                    out_last,
  output logic                    busy
);
  import npu_pkg::*;

  // Byte index of the final byte in a full word.
  localparam logic [1:0] FULL_IDX = 2'(LANES - 1);

  unpack_state_t             state_p1, state_nxt;
  logic [1:0]                idx_p1, idx_nxt;
  logic [1:0]                end_p1, end_nxt;
  logic                      last_p1, last_nxt;
  logic [LANES*BYTE_W-1:0]   word_p1, word_nxt;

  logic                      at_end;
  logic                      out_fire;
  logic                      in_fire;
  logic [BYTE_W-1:0]         byte_sel;

  // Handshake decode and next-state: retire/advance on output accept, load on input accept.
  always_comb begin
    at_end    = (idx_p1 == end_p1);
    out_fire  = (state_p1 == DRAIN) && out_ready;
    // out_ready feeds in_ready combinationally so a new word can load in the
    // same cycle the last byte of the current one leaves.
    in_ready  = !clear && ((state_p1 == IDLE) || (at_end && out_ready));
    in_fire   = in_valid && in_ready;

    state_nxt = state_p1;
    idx_nxt   = idx_p1;
    end_nxt   = end_p1;
    last_nxt  = last_p1;
    word_nxt  = word_p1;

    if (clear) begin
      state_nxt = IDLE;
      idx_nxt   = 2'd0;
      end_nxt   = 2'd0;
      last_nxt  = 1'b0;
      word_nxt  = '0;
    end else begin
      case (state_p1)
        IDLE: begin
          if (in_fire) begin
            state_nxt = DRAIN;
            idx_nxt   = 2'd0;
            end_nxt   = in_last ? in_count : FULL_IDX;
            last_nxt  = in_last;
            word_nxt  = in_data;
          end
        end
        DRAIN: begin
          if (out_fire) begin
            if (!at_end) begin
              idx_nxt = idx_p1 + 2'd1;
            end else if (in_fire) begin
              state_nxt = DRAIN;
              idx_nxt   = 2'd0;
              end_nxt   = in_last ? in_count : FULL_IDX;
              last_nxt  = in_last;
              word_nxt  = in_data;
            end else begin
              state_nxt = IDLE;
              idx_nxt   = 2'd0;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          idx_nxt   = 2'd0;
        end
      endcase
    end
  end

  // Held-word and control registers; reset drops any word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p1 <= IDLE;
      idx_p1   <= 2'd0;
      end_p1   <= 2'd0;
      last_p1  <= 1'b0;
      word_p1  <= '0;
    end else begin
      state_p1 <= state_nxt;
      idx_p1   <= idx_nxt;
      end_p1   <= end_nxt;
      last_p1  <= last_nxt;
      word_p1  <= word_nxt;
    end
  end

  // Output stage: select the current byte and widen it; driven only from registers and sign_ext.
  always_comb begin
    byte_sel  = word_p1[idx_p1*BYTE_W +: BYTE_W];
    out_valid = (state_p1 == DRAIN);
    busy      = out_valid;
    out_data  = out_valid ? ext_byte(byte_sel, sign_ext) : '0;
    out_last  = out_valid && last_p1 && at_end;
  end

endmodule

// File: tb/tb_unpack_stream.sv
// Scoreboard bench for unpack_stream: accepted words are expanded into the
// expected byte stream; a negedge monitor compares every presented element.
module tb_unpack_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        sign_ext = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic [1:0]  in_count = 2'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [23:0] out_data;
  logic        out_last;
  logic        busy;

  int checks = 0;
  int errors = 0;

  bit rdy_rand = 1'b0;
  bit se_rand  = 1'b0;

  // Expected elements: bit 8 = last flag, bits 7:0 = raw byte.
  logic [8:0] q[$];

  unpack_stream #(.LANES(4), .BYTE_W(8), .OUT_W(24)) dut (
    .clk(clk), .rst(rst), .clear(clear), .sign_ext(sign_ext),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_count(in_count),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference extension rule written arithmetically.
  function automatic logic [23:0] model_ext(input logic [7:0] b, input logic se);
    int v;
    v = int'(b);
    if (se && v >= 128) v = v - 256;
    return 24'(v);
  endfunction

  // Consumer back-pressure and sign_ext randomisation.
  always @(posedge clk) begin
    #1;
    out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (se_rand) sign_ext = 1'($urandom_range(0, 1));
  end

  // Monitor: compare presented element with queue head, expand accepted words.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 32'(out_valid), 32'd0);
        end else begin
          chk("out_data", 32'(out_data), 32'(model_ext(q[0][7:0], sign_ext)));
          chk("out_last", 32'(out_last), 32'(q[0][8]));
          if (out_ready && !clear) void'(q.pop_front());
        end
      end
      if (clear) begin
        q.delete();
      end else if (in_valid && in_ready) begin
        int e;
        e = in_last ? int'(in_count) : 3;
        for (int k = 0; k <= e; k++)
          q.push_back({(in_last && k == e), in_data[k*8 +: 8]});
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input logic l, input logic [1:0] c);
    int n;
    logic acc;
    in_valid = 1'b1; in_data = d; in_last = l; in_count = c;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 2000) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drained", 32'(q.size() == 0 && !out_valid), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset and idle output values.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_last",  32'(out_last),  32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk); #1;

    // Signed and unsigned expansion of 0x80FF017F.
    for (int s = 1; s >= 0; s--) begin
      sign_ext = 1'(s);
      send_word(32'h80FF017F, 1'b0, 2'd0);
      repeat (3) @(negedge clk);
      @(negedge clk);
      chk("in_ready_4th", 32'(in_ready), 32'd1);
      wait_drain();
    end

    // Three back-to-back words, final one partial: 10 bubble-free outputs.
    sign_ext = 1'b0;
    fork
      begin
        send_word(32'h44332211, 1'b0, 2'd0);
        send_word(32'h88776655, 1'b0, 2'd0);
        send_word(32'hCCBBAA99, 1'b1, 2'd1);
      end
      begin
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          chk("stream_valid", 32'(out_valid), 32'd1);
          chk("stream_last", 32'(out_last), 32'(i == 9));
        end
        @(negedge clk);
        chk("stream_idle", 32'(busy), 32'd0);
      end
    join
    wait_drain();

    // Random back-pressure, sign_ext, word gaps and partial last words.
    rdy_rand = 1'b1;
    se_rand  = 1'b1;
    for (int w = 0; w < 60; w++) begin
      logic l;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      l = (w == 59) ? 1'b1 : ($urandom_range(0, 3) == 0);
      send_word($urandom, l, 2'($urandom_range(0, 3)));
    end
    rdy_rand = 1'b0;
    se_rand  = 1'b0;
    wait_drain();

    // clear at idx 2 together with a waiting input word.
    sign_ext = 1'b1;
    send_word(32'hA1B2C3D4, 1'b0, 2'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    clear = 1'b1;
    in_valid = 1'b1; in_data = 32'h0F8E7D6C; in_last = 1'b1; in_count = 2'd3;
    @(negedge clk);
    chk("clear_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    chk("clear_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("after_clear_byte0", 32'(out_data), 32'h00006C);
    wait_drain();

    // Asynchronous reset in the middle of a word.
    send_word(32'h11223344, 1'b0, 2'd0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    q.delete();
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data",  32'(out_data),  32'd0);
    chk("arst_busy",      32'(busy),      32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("arst_in_ready",  32'(in_ready),  32'd1);
    chk("arst_idle",      32'(out_valid), 32'd0);
    send_word(32'h000000FE, 1'b1, 2'd0);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
